// File: rtl/ddr_arb_pkg.sv
// ----------------------------------------------------------------------------
// ddr_arb_pkg
// Shared definitions for the two-master DDR line-port arbiter.
//   arb_state_t : arbiter FSM encoding (IDLE / OWN / ABORT)
//   DCACHE      : master index of the data cache (master 0)
//   ICACHE      : master index of the instruction cache (master 1)
//   LINE_BITS   : width of one DDR line (read / write data)
//   MASK_BITS   : width of the byte-write mask for one line
// ----------------------------------------------------------------------------
package ddr_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN   = 2'd1,
        ST_ABORT = 2'd2
    } arb_state_t;

    localparam logic DCACHE = 1'b0;
    localparam logic ICACHE = 1'b1;

    localparam int LINE_BITS = 512;
    localparam int MASK_BITS = 64;

endpackage : ddr_arb_pkg

// File: rtl/ddr_arb_watchdog.sv
// ----------------------------------------------------------------------------
// ddr_arb_watchdog
// Counts strobe cycles that see no acknowledge during a tenure and flags the
// cycle in which the count would reach TIMEOUT.
//   i_clk, i_rstn : clock, asynchronous active-low reset
//   i_clr         : hold the counter at zero (arbiter not in OWN)
//   i_stb, i_ack  : slave-side strobe and acknowledge
//   o_expire      : high in the TIMEOUT-th unacknowledged strobe cycle
// ----------------------------------------------------------------------------
module ddr_arb_watchdog #(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_clr,
    input  logic i_stb,
    input  logic i_ack,
    output logic o_expire
);

    // Expiry is flagged one count early so the abort takes effect exactly
    // after TIMEOUT strobe cycles rather than one cycle later.
    localparam logic [15:0] LIMIT_M1 = 16'(TIMEOUT - 1);

    logic [15:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_cnt <= '0;
        end else if (i_clr || i_ack) begin
            r_cnt <= '0;
        end else if (i_stb) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    assign o_expire = i_stb & ~i_ack & (r_cnt == LIMIT_M1);

endmodule : ddr_arb_watchdog

// File: rtl/ddr_port_arbiter.sv
// ----------------------------------------------------------------------------
// ddr_port_arbiter
// Round-robin, cyc-locked Wishbone arbiter sharing the 512-bit DDR line port
// between the data cache (m0) and the instruction cache (m1).
//   clk, rstn          : DDR-side clock, asynchronous active-low reset
//   m{0,1}_addr/dout/dm/we/cyc/stb : master requests
//   m{0,1}_ack/err     : ack routed to the granted master, watchdog abort
//   m{0,1}_din         : read data, broadcast from s_din
//   s_addr/dout/dm/we/cyc/stb : muxed request to the DDR controller
//   s_ack, s_din       : DDR controller response
// Optional feature: define DDR_ARB_WATCHDOG_EN to abort tenures whose strobe
// goes unacknowledged for TIMEOUT cycles.
// ----------------------------------------------------------------------------
module ddr_port_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [31:0]          m0_addr,
    input  logic [31:0]          m1_addr,
    input  logic [LINE_BITS-1:0] m0_dout,
    input  logic [LINE_BITS-1:0] m1_dout,
    input  logic [MASK_BITS-1:0] m0_dm,
    input  logic [MASK_BITS-1:0] m1_dm,
    input  logic                 m0_we,
    input  logic                 m1_we,
    input  logic                 m0_cyc,
    input  logic                 m1_cyc,
    input  logic                 m0_stb,
    input  logic                 m1_stb,
    output logic                 m0_ack,
    output logic                 m1_ack,
    output logic                 m0_err,
    output logic                 m1_err,
    output logic [LINE_BITS-1:0] m0_din,
    output logic [LINE_BITS-1:0] m1_din,
    output logic [31:0]          s_addr,
    output logic [LINE_BITS-1:0] s_dout,
    output logic [MASK_BITS-1:0] s_dm,
    output logic                 s_we,
    output logic                 s_cyc,
    output logic                 s_stb,
    input  logic                 s_ack,
    input  logic [LINE_BITS-1:0] s_din
);

    if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("ddr_port_arbiter: TIMEOUT must lie in 2..65535");
    end

    arb_state_t r_state;
    arb_state_t w_state_nxt;
    logic       r_gnt;
    logic       r_last;
    logic       r_err;
    logic       w_gnt_nxt;
    logic       w_last_nxt;
    logic       w_err_nxt;

    logic       w_req0;
    logic       w_req1;
    logic       w_own;
    logic       w_gnt_cyc;
    logic       w_gnt_stb;
    logic       w_gnt_we;
    logic       w_expire;

    assign w_req0    = m0_cyc & m0_stb;
    assign w_req1    = m1_cyc & m1_stb;
    assign w_own     = (r_state == ST_OWN);
    assign w_gnt_cyc = (r_gnt == ICACHE) ? m1_cyc : m0_cyc;
    assign w_gnt_stb = (r_gnt == ICACHE) ? m1_stb : m0_stb;
    assign w_gnt_we  = (r_gnt == ICACHE) ? m1_we  : m0_we;

`ifdef DDR_ARB_WATCHDOG_EN
    // Counter is held clear outside OWN, so it restarts on every grant.
    ddr_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .i_clk    (clk),
        .i_rstn   (rstn),
        .i_clr    (~w_own),
        .i_stb    (s_stb),
        .i_ack    (s_ack),
        .o_expire (w_expire)
    );
`else
    assign w_expire = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_gnt   <= DCACHE;
            r_last  <= ICACHE;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_last  <= w_last_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_last_nxt  = r_last;
        w_err_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req0 || w_req1) begin
                    w_state_nxt = ST_OWN;
                    // On a tie the master that did not own the bus last wins.
                    if (w_req0 && w_req1) begin
                        w_gnt_nxt = ~r_last;
                    end else begin
                        w_gnt_nxt = w_req1 ? ICACHE : DCACHE;
                    end
                end
            end
            ST_OWN: begin
                // Release wins over a simultaneous expiry.
                if (!w_gnt_cyc) begin
                    w_state_nxt = ST_IDLE;
                    w_last_nxt  = r_gnt;
                end else if (w_expire) begin
                    w_state_nxt = ST_ABORT;
                    w_err_nxt   = 1'b1;
                end
            end
            ST_ABORT: begin
                if (!w_gnt_cyc) begin
                    w_state_nxt = ST_IDLE;
                    w_last_nxt  = r_gnt;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output logic: selects come only from registers; ack is a pure gate.
    always_comb begin
        s_addr = (r_gnt == ICACHE) ? m1_addr : m0_addr;
        s_dout = (r_gnt == ICACHE) ? m1_dout : m0_dout;
        s_dm   = (r_gnt == ICACHE) ? m1_dm   : m0_dm;
        s_we   = w_own & w_gnt_we;
        s_cyc  = w_own & w_gnt_cyc;
        s_stb  = w_own & w_gnt_stb;
        m0_ack = w_own & (r_gnt == DCACHE) & s_ack;
        m1_ack = w_own & (r_gnt == ICACHE) & s_ack;
        m0_err = r_err & (r_gnt == DCACHE);
        m1_err = r_err & (r_gnt == ICACHE);
        m0_din = s_din;
        m1_din = s_din;
    end

endmodule : ddr_port_arbiter

// File: doc/ddr_port_arbiter.md
# ddr_port_arbiter

Two-master Wishbone arbiter that shares the single 512-bit DDR line port between the data cache (master 0) and the instruction cache (master 1). Sits in the clkDDR domain between the caches' DDR-side FSMs and the DDR controller. Grants are round-robin and bus-locked for the whole `cyc` tenure, so a DCache read-then-writeback sequence is never split. An optional watchdog aborts tenures the slave never acknowledges.

## Interface
Parameters:
- `TIMEOUT`, 1023: watchdog limit in clk cycles of `stb` without `ack` (range 2..65535); ignored unless the watchdog is compiled in.

Ports:
- `clk`  in  1  DDR-side clock; all logic on rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `m0_addr`, `m1_addr`  in  32  master byte address, 64-byte aligned.
- `m0_dout`, `m1_dout`  in  512  master write data.
- `m0_dm`, `m1_dm`  in  64  master byte-write mask.
- `m0_we`, `m1_we`  in  1  master write strobe.
- `m0_cyc`, `m1_cyc`  in  1  master cycle, held for the locked tenure.
- `m0_stb`, `m1_stb`  in  1  master strobe.
- `m0_ack`, `m1_ack`  out  1  ack routed to the granted master only.
- `m0_err`, `m1_err`  out  1  watchdog abort, 1-cycle pulse.
- `m0_din`, `m1_din`  out  512  read data, broadcast from `s_din`.
- `s_addr`  out  32  muxed address to DDR.
- `s_dout`  out  512  muxed write data.
- `s_dm`  out  64  muxed mask.
- `s_we`, `s_cyc`, `s_stb`  out  1  muxed controls.
- `s_ack`  in  1  slave ack.
- `s_din`  in  512  slave read data.

## Operation
- States:
  - IDLE: no grant.
  - OWN: grant register `gnt` selects a master.
  - ABORT: only when the watchdog is compiled in.
- IDLE:
  - Request of master i is `mi_cyc & mi_stb`.
  - Single request: grant it.
  - Both requesting: grant the master not equal to `last`.
  - On grant: `gnt` is loaded and the state moves to OWN.
- OWN:
  - `s_cyc = m[gnt]_cyc`, `s_stb = m[gnt]_stb`; `s_addr/dout/dm/we` are muxed by `gnt`.
  - `m[gnt]_ack = s_ack`; the other master's ack is 0.
  - Multiple stb/ack beats are allowed inside one tenure.
- Release: when `m[gnt]_cyc` is low at a rising edge, the state returns to IDLE and `last <= gnt`.
  - There is no same-edge regrant, so bus turnaround is at least 1 idle cycle.
- The non-granted master waits with `cyc/stb` high and sees no ack. Its requests are not queued; it is simply re-sampled in IDLE.
- A master dropping `cyc` before its first ack ends the tenure normally. Any ack arriving later is discarded because the arbiter is in IDLE.
- Reset, including mid-tenure:
  - State goes to IDLE and `last = 1`, so master 0 wins the first tie.
  - `gnt = 0`, watchdog count = 0.
  - All `s_*` controls are 0, all `m*_ack`/`m*_err` are 0, and muxed data is don't-care.
- `m*_din` is always `s_din`, regardless of grant.

## Timing
- Grant latency: a request sampled at edge t in IDLE drives `s_cyc/s_stb` during cycle t+1. The slave sees it one cycle after the master raises it.
- Ack path is combinational, slave to master, with 0 added latency. All select signals come from registers.
- Back-to-back tenures: at least 1 IDLE cycle between release and next grant.
- Worst-case wait for a requester is one full tenure of the other master plus 2 cycles.

## Configuration
- Macro `DDR_ARB_WATCHDOG_EN`, when defined:
  - A 16-bit counter clears on entry to OWN and on every `s_ack`, and increments while `s_stb & ~s_ack`.
  - When the count reaches `TIMEOUT`:
    - `m[gnt]_err` pulses for 1 cycle.
    - The state moves to ABORT and `s_cyc`/`s_stb` are forced to 0.
    - ABORT exits to IDLE once `m[gnt]_cyc` is 0; `last <= gnt`.
- Not defined: no counter, no ABORT state, `m*_err` tied to 0, and tenures can last indefinitely.

## Structure
- Shared package `ddr_arb_pkg`:
  - State encoding: IDLE=2'd0, OWN=2'd1, ABORT=2'd2.
  - Master index constants: DCACHE=1'b0, ICACHE=1'b1.
  - `LINE_BITS=512`, `MASK_BITS=64`.
- One natural sub-module, `ddr_arb_watchdog` (counter plus compare, emits timeout pulse). It is instantiated only under the macro.

## Test plan
- Reset, then `m0` requests a read and the slave acks 4 cycles later → `s_cyc` high at cycle 1, `m0_ack` pulses in the ack cycle, `m1_ack` stays 0, `m0_din == s_din`.
- Both masters raise `cyc/stb` in the same cycle right after reset → `m0` granted first. After `m0` releases, exactly 1 idle cycle, then `m1` granted with `s_addr == m1_addr`.
- `m0` does a read, holds `cyc` high, then does a write (two acks) while `m1` requests throughout → `m1` is not granted until `m0_cyc` falls.
- `rstn` asserted mid-tenure with `s_stb` high → `s_cyc/s_stb` drop immediately (asynchronous). After release, a tie grants `m0`.
- With `DDR_ARB_WATCHDOG_EN` and `TIMEOUT=8`, the slave never acks → `m0_err` pulses after 8 stb cycles and `s_cyc` goes to 0. Once `m0` drops `cyc`, a pending `m1` is granted.
- Without the macro, same stimulus → no `m0_err`, `s_stb` held indefinitely.
